// File: rtl/dac_sample_interp.sv
// ---------------------------------------------------------------------------
// dac_sample_interp
//
// This block feeds the second-order sigma-delta DAC. It accepts audio
// samples at the low sample rate and produces one linearly interpolated
// value every clk. Each sample period lasts 2^OSR_LOG2 clocks.
//
// Each sample boundary becomes a ramp. At startup the output ramps up from
// 0. On underflow (no new sample ready at a period boundary) the output
// holds the last value and underflow pulses for one clk.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   sample_in     signed input sample, Q1.(DW-1)
//   sample_valid  sample_in is valid
//   sample_ready  block can accept a sample this cycle
//   dout          signed Q(NBITS).(MBITS) interpolated value, goes to DAC din
//   underflow     one-clk pulse: period boundary reached with nothing pending
// ---------------------------------------------------------------------------
module dac_sample_interp #(
    parameter int NBITS    = 2,
    parameter int MBITS    = 16,
    parameter int DW       = 16,
    parameter int OSR_LOG2 = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DW-1:0]                 sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic signed [NBITS+MBITS-1:0] dout,
    output logic                          underflow
);

    localparam int TOT  = NBITS + MBITS;
    localparam int ACCW = TOT + OSR_LOG2 + 1;
    localparam int DELW = TOT + 1;
    localparam int SH   = MBITS - (DW - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

    logic [0:0]                state_q, state_d;
    logic [DW-1:0]             pend_q, pend_d;
    logic                      pend_valid_q, pend_valid_d;
    logic signed [TOT-1:0]     nxt_q, nxt_d;
    logic signed [DELW-1:0]    delta_q, delta_d;
    logic signed [ACCW-1:0]    acc_q, acc_d;
    logic [OSR_LOG2-1:0]       phase_q, phase_d;

    logic                      boundary;
    logic                      xfer;
    logic                      load;
    logic signed [TOT-1:0]     src;
    logic signed [TOT-1:0]     pend_sx;
    logic signed [TOT-1:0]     pend_ext;

    assign boundary     = (state_q == ST_RUN) && (phase_q == PHASE_LAST);
    assign sample_ready = !pend_valid_q || boundary;
    assign xfer         = sample_valid && sample_ready;
    assign underflow    = boundary && !pend_valid_q;

    // Convert the pending sample from Q1.(DW-1) to Q(NBITS).(MBITS):
    // first sign-extend it, then align the binary point.
    assign pend_sx  = TOT'($signed(pend_q));
    assign pend_ext = pend_sx <<< SH;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        nxt_d        = nxt_q;
        delta_d      = delta_q;
        acc_d        = acc_q;
        phase_d      = phase_q;
        load         = 1'b0;
        src          = nxt_q;

        if (state_q == ST_IDLE) begin
            if (pend_valid_q) begin
                load    = 1'b1;
                src     = pend_ext;
                state_d = ST_RUN;
            end
        end else if (boundary) begin
            // If nothing is pending, reload the current endpoint.
            // That gives delta = 0, so the output holds.
            load = 1'b1;
            src  = pend_valid_q ? pend_ext : nxt_q;
        end else begin
            acc_d   = acc_q + {{OSR_LOG2{delta_q[DELW-1]}}, delta_q};
            phase_d = phase_q + OSR_LOG2'(1);
        end

        // acc starts each period at exactly the old endpoint, scaled by N.
        // This stops rounding drift carrying over between periods. delta
        // is one bit wider than a sample, so a full-scale swing cannot wrap.
        if (load) begin
            nxt_d   = src;
            delta_d = {src[TOT-1], src} - {nxt_q[TOT-1], nxt_q};
            acc_d   = {nxt_q[TOT-1], nxt_q, {OSR_LOG2{1'b0}}};
            phase_d = '0;
            if (pend_valid_q) begin
                pend_valid_d = 1'b0;
            end
        end

        // An incoming sample takes priority over the consume above. A new
        // sample arriving on the same boundary refills the buffer.
        if (xfer) begin
            pend_d       = sample_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            nxt_q        <= '0;
            delta_q      <= '0;
            acc_q        <= '0;
            phase_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            nxt_q        <= nxt_d;
            delta_q      <= delta_d;
            acc_q        <= acc_d;
            phase_q      <= phase_d;
        end
    end

    // dout is acc >>> OSR_LOG2, truncated to TOT bits: a plain slice of acc.
    assign dout = acc_q[OSR_LOG2 +: TOT];

    // The guard bit and the sub-LSB fraction bits of acc never reach dout.
    logic acc_unused;
    assign acc_unused = ^{acc_q[ACCW-1], acc_q[OSR_LOG2-1:0]};

endmodule

// File: tb/tb_dac_sample_interp.sv
module tb_dac_sample_interp;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Narrow instance: N = 4
    logic [15:0]        a_in = '0;
    logic               a_valid = 1'b0;
    logic               a_ready;
    logic signed [17:0] a_dout;
    logic               a_uf;

    // Wide instance: N = 256
    logic [15:0]        b_in = '0;
    logic               b_valid = 1'b0;
    logic               b_ready;
    logic signed [17:0] b_dout;
    logic               b_uf;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dac_sample_interp #(.NBITS(2), .MBITS(16), .DW(16), .OSR_LOG2(2)) u_dut (
        .clk(clk), .reset(reset), .sample_in(a_in), .sample_valid(a_valid),
        .sample_ready(a_ready), .dout(a_dout), .underflow(a_uf)
    );

    dac_sample_interp #(.NBITS(2), .MBITS(16), .DW(16), .OSR_LOG2(8)) u_dut_wide (
        .clk(clk), .reset(reset), .sample_in(b_in), .sample_valid(b_valid),
        .sample_ready(b_ready), .dout(b_dout), .underflow(b_uf)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Hand-computed dout values.
    int exp_steady [10] = '{0, 8192, 16384, 24576, 32768, 32768, 32768, 32768, 32768, 32768};
    int exp_swing  [10] = '{8192, 16384, 24576, 32768, 16384, 0, -16384, -32768, -32768, -32768};
    int exp_uf_d   [21] = '{0, 4096, 8192, 12288,
                            16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384,
                            16384, 16384, 16384, 16384, 16384, 24576, 32768, 40960, 49152};
    int exp_uf_p   [21] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1,
                            0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        int prev;
        int mono_err;
        int uf_err;
        int cnt;
        logic r;

        // 1. Reset and idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle_dout[%0d]", i), a_dout, 0);
            check($sformatf("idle_ready[%0d]", i), a_ready, 1);
            check($sformatf("idle_uf[%0d]", i), a_uf, 0);
        end
        check("idle_wide_dout", b_dout, 0);

        // 2. Startup ramp to 0x4000, sample kept available
        do_reset();
        a_in = 16'h4000; a_valid = 1'b1;
        tick();
        check("start_k1", a_dout, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("steady_k%0d", i + 2), a_dout, exp_steady[i]);
            check($sformatf("steady_uf_k%0d", i + 2), a_uf, 0);
        end

        // 3. 0x4000 then 0xC000
        do_reset();
        a_in = 16'h4000; a_valid = 1'b1;
        tick();
        tick();
        check("swing_k2", a_dout, 0);
        a_in = 16'hC000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("swing_k%0d", i + 3), a_dout, exp_swing[i]);
        end
        a_valid = 1'b0;

        // 4. Full-scale swing on the N=256 instance
        do_reset();
        b_in = 16'h7FFF; b_valid = 1'b1;
        tick();
        tick();
        b_in = 16'h8000;
        prev = 0; mono_err = 0; uf_err = 0;
        for (int k = 3; k <= 515; k++) begin
            tick();
            if (b_uf) uf_err++;
            if (k >= 259 && k <= 514 && b_dout >= prev) mono_err++;
            if (k == 257) check("wide_k257", b_dout, 65278);
            if (k == 258) check("wide_top", b_dout, 65534);
            if (k == 386) check("wide_mid", b_dout, -1);
            if (k == 513) check("wide_k513", b_dout, -65025);
            if (k == 514) check("wide_bottom", b_dout, -65536);
            if (k == 515) check("wide_hold", b_dout, -65536);
            prev = b_dout;
        end
        check("wide_monotonic_errs", mono_err, 0);
        check("wide_uf_count", uf_err, 0);
        b_valid = 1'b0;

        // 5. Underflow hold after 0x2000, then resume with 0x6000
        do_reset();
        a_in = 16'h2000; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i + 2 == 14) begin
                a_in = 16'h6000; a_valid = 1'b1;
            end
            tick();
            if (i + 2 == 14) a_valid = 1'b0;
            check($sformatf("uf_dout_k%0d", i + 2), a_dout, exp_uf_d[i]);
            check($sformatf("uf_pulse_k%0d", i + 2), a_uf, exp_uf_p[i]);
        end

        // 6. Back-pressure with an incrementing count
        do_reset();
        cnt = 1;
        a_in = 16'(cnt); a_valid = 1'b1;
        uf_err = 0;
        for (int k = 0; k < 22; k++) begin
            check($sformatf("bp_ready_k%0d", k), a_ready,
                  (k == 0 || k == 2 || (k >= 5 && (k - 5) % 4 == 0)) ? 1 : 0);
            r = a_ready;
            tick();
            if (r) cnt++;
            a_in = 16'(cnt);
            if (a_uf) uf_err++;
            if (k + 1 >= 6 && (k + 1 - 2) % 4 == 0)
                check($sformatf("bp_endpoint_k%0d", k + 1), a_dout, 2 * ((k + 1 - 2) / 4));
        end
        check("bp_transfers", cnt - 1, 7);
        check("bp_uf_count", uf_err, 0);
        a_valid = 1'b0;

        // 7. Asynchronous reset mid-ramp
        do_reset();
        a_in = 16'h4000; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_before_reset", a_dout, 16384);
        #3 reset = 1'b1;
        #1;
        check("async_reset_dout", a_dout, 0);
        check("async_reset_ready", a_ready, 1);
        a_valid = 1'b0;
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_dout[%0d]", i), a_dout, 0);
            check($sformatf("post_reset_uf[%0d]", i), a_uf, 0);
        end
        a_in = 16'h2000; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        check("restart_k1", a_dout, 0);
        tick();
        check("restart_k2", a_dout, 0);
        tick();
        check("restart_k3", a_dout, 4096);
        tick();
        check("restart_k4", a_dout, 8192);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dac_sample_interp.md
Name: dac_sample_interp

Overview:
- Upstream feeder for the second-order sigma-delta DAC.
- Accepts audio samples at the low sample rate over a valid/ready handshake.
- Linearly interpolates between consecutive samples, with one new value every clk, across a period of 2^OSR_LOG2 clocks.
- Drives the DAC's signed Q(NBITS).(MBITS) input. Each sample boundary becomes a ramp instead of a step; startup ramps up from 0 and underflow holds the last value.

Parameters:
- NBITS, 2, integer bits of output format (must match DAC NBITS).
- MBITS, 16, fractional bits of output format (must match DAC MBITS).
- DW, 16, input sample width, signed Q1.(DW-1); MBITS >= DW-1 required.
- OSR_LOG2, 8, log2 of clocks per input sample period (N = 2^OSR_LOG2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  DW  signed input sample, Q1.(DW-1).
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  block can accept sample this cycle.
- dout  out  NBITS+MBITS  signed interpolated value to DAC din.
- underflow  out  1  one-clk pulse: period boundary reached with no pending sample.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high. All state clears immediately on reset assertion.
- Reset values: dout=0, sample_ready=1, underflow=0, state=IDLE, pending buffer empty, cur=nxt=0, acc=0, phase=0.
- Format conversion: ext(s) = sign-extend sample_in to TOT_BITS=NBITS+MBITS, then shift left by MBITS-(DW-1). With the defaults, 0x4000 (0.5) becomes 32768 and 0x7FFF becomes 65534.
- Pending buffer: 1 entry (pend, pend_valid).
  - sample_ready = !pend_valid || (state==RUN && boundary).
  - A transfer occurs when sample_valid && sample_ready. sample_in is registered into pend; pend_valid is set.
- Datapath:
  - acc: signed, TOT_BITS+OSR_LOG2+1 bits.
  - delta = nxt - cur: signed, TOT_BITS+1 bits. No wrap, even at full-scale swing.
  - dout = acc arithmetically shifted right by OSR_LOG2, low TOT_BITS bits. dout is a direct slice of the registered acc.
- Load operation (new period): cur <= nxt; nxt <= source; delta <= source - nxt; acc <= nxt << OSR_LOG2; phase <= 0.
- States:
  - IDLE: acc held at 0, phase halted. When pend_valid=1, perform a load with source=pend, clear pend_valid, go to RUN. The first period therefore ramps from 0 to the first sample.
  - RUN, non-boundary (phase != N-1): acc <= acc+delta; phase <= phase+1.
  - RUN, boundary (phase == N-1): load.
    - If pend_valid=1 (value before any same-cycle write): source=pend. A same-cycle incoming sample overwrites pend and pend_valid stays 1.
    - If pend_valid=0: source=nxt (hold, delta=0) and underflow=1 for this clk. A same-cycle incoming sample is written to pend and is used at the next boundary.
  - RUN is left only by reset.
- Per-period output: cur, cur+delta/N, ..., cur+(N-1)*delta/N (floor), then exactly nxt at the next period start. acc is exact, so there is no drift accumulation.
- Latency: sample accepted at edge t → pend_valid at t+1 → (IDLE) load at edge t+1 → dout equals the previous nxt at t+1 and reaches the new value exactly N clocks later.
- Throughput: at most one sample per N clocks is consumed. Excess samples are back-pressured via sample_ready=0 and are never dropped.

Test Plan (OSR_LOG2=2, N=4 unless noted):
- Reset, then idle 10 clks → dout=0, sample_ready=1, underflow=0 throughout. No dout change without input.
- From IDLE, send 0x4000 then keep 0x4000 available → dout sequence 0,8192,16384,24576, then 32768 held constant. No underflow pulses.
- Steady at 0x4000, then 0xC000 (-0.5) → dout 32768,16384,0,-16384, then -32768.
- Full swing 0x7FFF then 0x8000 with OSR_LOG2=8 → dout decreases monotonically from 65534 to -65536 over 256 clks. No wrap; final value exact.
- Stop supplying samples after 0x2000 → underflow pulses for one clk at each boundary (every 4 clks); dout holds 16384. The next sample then resumes ramping from 16384.
- Hold sample_valid high with an incrementing count 1,2,3,...:
  - exactly one transfer per 4 clks;
  - sample_ready low between transfers;
  - period endpoints in order 1,2,3,..., none skipped or duplicated.
- Assert reset mid-ramp → dout=0 asynchronously and pend is dropped. After release, the next sample ramps from 0 as in IDLE startup.
